// File: rtl/periph_bus_pkg.sv
// rtl/periph_bus_pkg.sv - size encodings, FSM states and zero-extend helper for the peripheral bus
package periph_bus_pkg;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} bus_state_t;

  // Shared with responders so both ends agree on which lanes are meaningful.
  function automatic logic [63:0] zext_by_size(input logic [63:0] data, input logic [1:0] sz);
    logic [63:0] r;
    case (sz)
      SIZE_BYTE: r = {56'd0, data[7:0]};
      SIZE_HALF: r = {48'd0, data[15:0]};
      SIZE_WORD: r = {32'd0, data[31:0]};
      default:   r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/periph_bus_tristate.sv
// rtl/periph_bus_tristate.sv - tri-state driver for the shared peripheral data bus
module periph_bus_tristate #(
  parameter int WIDTH = 64
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] dout,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = oe ? dout : {WIDTH{1'bz}};

endmodule

// File: rtl/periph_bus_master.sv
// rtl/periph_bus_master.sv - single-outstanding peripheral bus master with strobed tri-state data bus
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [1:0]            size,
  output logic                  mem_read,
  output logic                  mem_write,
  inout  wire  [DATA_WIDTH-1:0] data_bi
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  bus_state_t            state, state_next;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            cnt;
  logic                  accept;
  logic                  last_access;

  assign req_ready   = (state == IDLE);
  assign accept      = req_valid && req_ready;
  assign last_access = (state == ACCESS) && (cnt == 4'd0);
  assign rsp_valid   = (state == RESP);
  // Strobes decode straight from state so an async reset drops them at once.
  assign mem_write   = (state == ACCESS) && write_q;
  assign mem_read    = (state == ACCESS) && !write_q;
  assign address     = addr_q;
  assign size        = size_q;
  assign rsp_rdata   = rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_next = HOLD;
      HOLD:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= SIZE_DOUBLE;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      // The address/size registers double as the bus outputs, so they hold between accesses.
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == SETUP) begin
        cnt <= CNT_LOAD;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (last_access && !write_q) begin
        rdata_q <= DATA_WIDTH'(zext_by_size(64'(data_bi), size_q));
      end
    end
  end

  periph_bus_tristate #(
    .WIDTH (DATA_WIDTH)
  ) u_tristate (
    .oe   (mem_write),
    .dout (wdata_q),
    .bus  (data_bi)
  );

endmodule
